// File: rtl/bist_controller.sv
// BIST sequencer for a core FSM: LFSR impact generator, MISR response compactor, golden compare.
// Optional macro BIST_SYNC_TIMEOUT_EN bounds the SYNC phase and reports a timeout through bist_err.
module bist_controller #(
    parameter int unsigned N_PATTERNS   = 256,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [15:0] GOLDEN_SIG   = 16'h0000,
    parameter logic [3:0]  HOLD_IMPACT  = 4'b0100,
    parameter int unsigned SYNC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bist_start,
    input  logic [3:0]  core_result,
    output logic [3:0]  core_impact,
    output logic        core_sel,
    output logic        bist_busy,
    output logic        bist_done,
    output logic        bist_pass,
    output logic        bist_err,
    output logic [15:0] signature
);

    // An all-zero seed would lock the LFSR, so it is swapped for the default.
    localparam logic [15:0] SEED         = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [15:0] LAST_PATTERN = 16'(N_PATTERNS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        RUN,
        FLUSH,
        COMPARE,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [15:0] lfsr;
    logic [15:0] misr;
    logic [15:0] pat_cnt;
    logic        capture;
    logic        pass_q;

    logic load_seed;
    logic lfsr_advance;
    logic misr_clear;
    logic cnt_clear;
    logic cnt_inc;
    logic flags_clear;
    logic pass_load;

    // Polynomial x^16+x^14+x^13+x^11+1, shifting toward the MSB.
    function automatic logic [15:0] poly_shift(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

`ifdef BIST_SYNC_TIMEOUT_EN
    localparam logic [15:0] SYNC_LAST = 16'(SYNC_TIMEOUT - 1);

    logic [15:0] sync_cnt;
    logic        sync_clear;
    logic        sync_inc;
    logic        err_set;
    logic        err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        load_seed    = 1'b0;
        lfsr_advance = 1'b0;
        misr_clear   = 1'b0;
        cnt_clear    = 1'b0;
        cnt_inc      = 1'b0;
        flags_clear  = 1'b0;
        pass_load    = 1'b0;
        core_sel     = 1'b0;
        core_impact  = 4'b0000;
        bist_busy    = 1'b0;
        bist_done    = 1'b0;
`ifdef BIST_SYNC_TIMEOUT_EN
        sync_clear   = 1'b0;
        sync_inc     = 1'b0;
        err_set      = 1'b0;
`endif
        case (state)
            IDLE, DONE: begin
                bist_done = (state == DONE);
                if (bist_start) begin
                    next_state  = SYNC;
                    load_seed   = 1'b1;
                    misr_clear  = 1'b1;
                    flags_clear = 1'b1;
`ifdef BIST_SYNC_TIMEOUT_EN
                    sync_clear  = 1'b1;
`endif
                end
            end
            // Walk the core with pseudo-random impacts until it reaches its reset state.
            SYNC: begin
                core_sel  = 1'b1;
                bist_busy = 1'b1;
                if (core_result == 4'b0000) begin
                    core_impact = HOLD_IMPACT;
                    load_seed   = 1'b1;
                    misr_clear  = 1'b1;
                    cnt_clear   = 1'b1;
                    next_state  = RUN;
                end else begin
                    core_impact  = lfsr[3:0];
                    lfsr_advance = 1'b1;
`ifdef BIST_SYNC_TIMEOUT_EN
                    if (sync_cnt == SYNC_LAST) begin
                        err_set    = 1'b1;
                        next_state = DONE;
                    end else begin
                        sync_inc = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                core_sel     = 1'b1;
                bist_busy    = 1'b1;
                core_impact  = lfsr[3:0];
                lfsr_advance = 1'b1;
                cnt_inc      = 1'b1;
                if (pat_cnt == LAST_PATTERN) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                core_sel    = 1'b1;
                bist_busy   = 1'b1;
                core_impact = HOLD_IMPACT;
                next_state  = COMPARE;
            end
            COMPARE: begin
                bist_busy  = 1'b1;
                pass_load  = 1'b1;
                next_state = DONE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The core answers one cycle late, so capture trails each RUN cycle by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr    <= SEED;
            misr    <= 16'h0000;
            pat_cnt <= 16'h0000;
            capture <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            capture <= (state == RUN);

            if (load_seed) begin
                lfsr <= SEED;
            end else if (lfsr_advance) begin
                lfsr <= poly_shift(lfsr);
            end

            if (misr_clear) begin
                misr <= 16'h0000;
            end else if (capture) begin
                misr <= poly_shift(misr) ^ {12'h000, core_result};
            end

            if (cnt_clear) begin
                pat_cnt <= 16'h0000;
            end else if (cnt_inc) begin
                pat_cnt <= pat_cnt + 16'd1;
            end

            if (flags_clear) begin
                pass_q <= 1'b0;
            end else if (pass_load) begin
                pass_q <= (misr == GOLDEN_SIG);
            end
        end
    end

`ifdef BIST_SYNC_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_cnt <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            if (sync_clear) begin
                sync_cnt <= 16'h0000;
            end else if (sync_inc) begin
                sync_cnt <= sync_cnt + 16'd1;
            end

            if (flags_clear) begin
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bist_err = err_q;
`else
    assign bist_err = 1'b0;
`endif

    assign bist_pass = pass_q;
    assign signature = misr;

endmodule

// File: doc/bist_controller.md
BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N_PATTERNS, 256, number of test impacts applied in RUN; 16-bit, legal range 1..65535.
- LFSR_SEED, 16'hACE1, pattern LFSR seed; a value of 0 is replaced by 16'hACE1.
- GOLDEN_SIG, 16'h0000, expected final MISR signature.
- HOLD_IMPACT, 4'b0100, impact that leaves the core in state 4'b0000.
- SYNC_TIMEOUT, 64, SYNC cycle limit; used only with BIST_SYNC_TIMEOUT_EN.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; every register updates on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- bist_start, in, 1, single-cycle start request.
- core_result, in, 4, registered state output of the core FSM under test.
- core_impact, out, 4, impact vector driven to the core when core_sel=1.
- core_sel, out, 1, 1 = controller drives the core impact mux, 0 = functional path.
- bist_busy, out, 1, test in progress.
- bist_done, out, 1, test finished; holds until the next accepted start.
- bist_pass, out, 1, signature matched; valid while bist_done=1.
- bist_err, out, 1, SYNC timeout occurred; valid while bist_done=1.
- signature, out, 16, current MISR contents.

Function
REQ-003 FSM states: IDLE, SYNC, RUN, FLUSH, COMPARE, DONE.
REQ-004 bist_start is accepted only in IDLE or DONE; an accepted start enters SYNC next cycle and clears done/pass/err, loads the LFSR with the seed and clears the MISR.
REQ-005 bist_start in SYNC, RUN, FLUSH or COMPARE is ignored with no side effect.
REQ-006 SYNC, per cycle:
- core_result!=4'b0000: drive core_impact=lfsr[3:0] and advance the LFSR.
- core_result==4'b0000: drive core_impact=HOLD_IMPACT (combinational, same cycle), reload the LFSR with the seed, clear the MISR, clear the pattern counter, go to RUN.
REQ-007 RUN:
- Drive core_impact=lfsr[3:0] each cycle, advance the LFSR, increment the 16-bit pattern counter.
- Leave for FLUSH after exactly N_PATTERNS RUN cycles.
REQ-008 LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifts toward the MSB with feedback into bit 0.
REQ-009 MISR: same polynomial; each update is next = shift(misr) XOR {12'b0, core_result}.
REQ-010 Capture timing:
- The core has one-cycle latency, so the MISR updates in the cycle after each RUN cycle, i.e. in RUN cycles 2..N and in FLUSH.
- Exactly N_PATTERNS captures occur.
- The MISR is frozen in all other states.
REQ-011 FLUSH lasts 1 cycle and drives core_impact=HOLD_IMPACT.
REQ-012 COMPARE lasts 1 cycle: bist_pass <= (misr==GOLDEN_SIG), then go to DONE.
REQ-013 DONE: bist_done=1; pass, err and signature are held.
REQ-014 Output decode:
- core_sel=1 in SYNC, RUN and FLUSH; otherwise 0.
- core_impact=4'b0000 whenever core_sel=0.
REQ-015 bist_busy=1 in SYNC, RUN, FLUSH and COMPARE.
REQ-016 Latency: with core_result already 0, start to bist_done=1 is 1+1+N_PATTERNS+1+1 cycles (260 for N=256).

Reset
REQ-017 While rst=1, at the next edge:
- State=IDLE, LFSR=seed, MISR=0, pattern counter=0.
- bist_busy=0, bist_done=0, bist_pass=0, bist_err=0, core_sel=0, core_impact=0.
REQ-018 rst has priority over bist_start and over every state, including mid-RUN; the core is returned to the functional path the cycle after rst is sampled.

Configuration
REQ-019 Macro BIST_SYNC_TIMEOUT_EN:
- Defined: a SYNC cycle counter runs. If core_result!=0 after SYNC_TIMEOUT SYNC cycles, go to DONE with bist_err=1 and bist_pass=0, skipping RUN.
- Undefined: SYNC waits indefinitely and bist_err is tied 0.

Verification
REQ-020 Reset: assert rst for 2 cycles mid-operation -> every output equals its REQ-017 value the cycle after the first rst edge.
REQ-021 Core stub at state 0, GOLDEN_SIG set to the model signature, pulse bist_start -> bist_busy high 259 cycles, then done=1, pass=1, signature=GOLDEN_SIG.
REQ-022 Same run with GOLDEN_SIG XOR 16'h0001 -> done=1, pass=0, err=0.
REQ-023 Pulse bist_start at RUN cycle 10 -> no restart; done still at cycle 260 with an identical signature.
REQ-024 BIST_SYNC_TIMEOUT_EN defined, core_result stuck at 4'b0101 -> done=1, err=1, pass=0 after 64 SYNC cycles; core_sel=0 afterwards.
REQ-025 rst at RUN cycle 100, then bist_start -> the full sequence reruns and yields the same signature as REQ-021.
